wb_stage: RTL and testbench

- Writeback stage of the 5-stage RV32I pipeline, fed by the MEM stage and directly driving the register file write port (wen/waddr/wdata).
- Holds one instruction in a stage register and waits for late load data from data memory.
- Aligns and sign- or zero-extends load data, selects the writeback source, and publishes forwarding and debug info.

---
 rtl/wb_stage_if.sv | 22 ++
 rtl/wb_stage.sv | 137 +++++++++++++
 tb/tb_wb_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM -> WB stage handshake and instruction payload.
// MEM drives the instruction fields; WB answers with ws_allowin.
interface wb_stage_if;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [4:0]  ms_rd;
    logic        ms_rf_we;
    logic [1:0]  ms_wb_sel;
    logic [2:0]  ms_funct3;
    logic [31:0] ms_alu_result;

    modport master (
        output ms_valid, ms_pc, ms_rd, ms_rf_we, ms_wb_sel, ms_funct3, ms_alu_result,
        input  ws_allowin
    );

    modport slave (
        input  ms_valid, ms_pc, ms_rd, ms_rf_we, ms_wb_sel, ms_funct3, ms_alu_result,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// RV32I writeback stage: holds one instruction, waits for load data, extends it and writes the regfile.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int          XLEN   = 32,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            resetn,
    wb_stage_if.slave       ms,
    input  logic            data_rvalid,
    input  logic [XLEN-1:0] data_rdata,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            ws_fwd_valid,
    output logic            ws_fwd_ready,
    output logic [4:0]      ws_fwd_rd,
    output logic [XLEN-1:0] ws_fwd_data,
    output logic [XLEN-1:0] debug_wb_pc,
    output logic [63:0]     retire_cnt
);
    logic            ws_valid_reg;
    logic [XLEN-1:0] pc_reg;
    logic [4:0]      rd_reg;
    logic            rf_we_reg;
    logic [1:0]      wb_sel_reg;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] alu_reg;
    logic            ld_done_reg;
    logic [XLEN-1:0] ld_buf_reg;

    logic            is_load;
    logic            ready_go;
    logic            allowin;
    logic            retire;
    logic            capture;
    logic [1:0]      off;
    logic [XLEN-1:0] word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] wb_value;

    assign is_load  = (wb_sel_reg == 2'b01);
    assign ready_go = !is_load || ld_done_reg || data_rvalid;
    assign allowin  = !ws_valid_reg || ready_go;
    assign retire   = ws_valid_reg && ready_go;
    // Only the first data beat for a held, still-waiting load is taken.
    assign capture  = ws_valid_reg && is_load && !ld_done_reg && data_rvalid;

    assign ms.ws_allowin = allowin;

    assign off  = alu_reg[1:0];
    assign word = (data_rvalid && !ld_done_reg) ? data_rdata : ld_buf_reg;

    always_comb begin
        case (off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];

        case (funct3_reg)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_value = {24'd0, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_value = {16'd0, half_sel};
            default: load_value = word;
        endcase

        case (wb_sel_reg)
            2'b01:   wb_value = load_value;
            2'b10:   wb_value = pc_reg + 32'd4;
            default: wb_value = alu_reg;
        endcase
    end

    assign rf_wen       = retire && rf_we_reg && (rd_reg != 5'd0);
    assign rf_waddr     = rd_reg;
    assign rf_wdata     = wb_value;
    assign ws_fwd_valid = ws_valid_reg && rf_we_reg && (rd_reg != 5'd0);
    // Gated by ws_valid so an empty stage never claims final data.
    assign ws_fwd_ready = ws_valid_reg && ready_go;
    assign ws_fwd_rd    = rd_reg;
    assign ws_fwd_data  = wb_value;
    assign debug_wb_pc  = pc_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_reg <= 1'b0;
            pc_reg       <= RST_PC;
            rd_reg       <= 5'd0;
            rf_we_reg    <= 1'b0;
            wb_sel_reg   <= 2'b00;
            funct3_reg   <= 3'b000;
            alu_reg      <= '0;
            ld_done_reg  <= 1'b0;
            ld_buf_reg   <= '0;
        end else begin
            if (ms.ms_valid && allowin) begin
                ws_valid_reg <= 1'b1;
                pc_reg       <= ms.ms_pc;
                rd_reg       <= ms.ms_rd;
                rf_we_reg    <= ms.ms_rf_we;
                wb_sel_reg   <= ms.ms_wb_sel;
                funct3_reg   <= ms.ms_funct3;
                alu_reg      <= ms.ms_alu_result;
                ld_done_reg  <= 1'b0;
            end else begin
                if (retire)
                    ws_valid_reg <= 1'b0;
                // Keep captured data only if the instruction could not leave this cycle.
                if (capture && !retire)
                    ld_done_reg <= 1'b1;
            end
            if (capture)
                ld_buf_reg <= data_rdata;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            retire_cnt_reg <= 64'd0;
        else if (retire)
            retire_cnt_reg <= retire_cnt_reg + 64'd1;
    end

    assign retire_cnt = retire_cnt_reg;
`else
    assign retire_cnt = 64'd0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        resetn;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic        ws_fwd_ready;
    logic [4:0]  ws_fwd_rd;
    logic [31:0] ws_fwd_data;
    logic [31:0] debug_wb_pc;
    logic [63:0] retire_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_retired = 64'd0;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    wb_stage_if bus ();

    wb_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .ms           (bus.slave),
        .data_rvalid  (data_rvalid),
        .data_rdata   (data_rdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .ws_fwd_valid (ws_fwd_valid),
        .ws_fwd_ready (ws_fwd_ready),
        .ws_fwd_rd    (ws_fwd_rd),
        .ws_fwd_data  (ws_fwd_data),
        .debug_wb_pc  (debug_wb_pc),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        bus.ms_valid      = 1'b0;
        bus.ms_pc         = 32'd0;
        bus.ms_rd         = 5'd0;
        bus.ms_rf_we      = 1'b0;
        bus.ms_wb_sel     = 2'b00;
        bus.ms_funct3     = 3'b000;
        bus.ms_alu_result = 32'd0;
    endtask

    task automatic put_instr(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                             input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu);
        bus.ms_valid      = 1'b1;
        bus.ms_pc         = pc;
        bus.ms_rd         = rd;
        bus.ms_rf_we      = we;
        bus.ms_wb_sel     = sel;
        bus.ms_funct3     = f3;
        bus.ms_alu_result = alu;
    endtask

    // Load result computed from byte/halfword arithmetic on the word value.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        int          o;
        o = int'(off);
        b = (w >> (8 * o)) & 32'd255;
        h = (w >> (16 * (o / 2))) & 32'd65535;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic test_reset();
        resetn      = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = 32'd0;
        bus_idle();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b want 1", bus.ws_allowin); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", rf_wen); end
        checks++; if (ws_fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got %b want 0", ws_fwd_valid); end
        checks++; if (ws_fwd_ready !== 1'b0) begin errors++; $display("FAIL reset_fwd_ready got %b want 0", ws_fwd_ready); end
        checks++; if (debug_wb_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", debug_wb_pc); end
        checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
        @(negedge clk);
        resetn      = 1'b1;
        exp_retired = 64'd0;
        $display("reset released");
    endtask

    task automatic test_alu();
        @(negedge clk);
        put_instr(32'h100, 5'd5, 1'b1, 2'b00, 3'b000, 32'h0000_1234);
        #1;
        checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL alu_allowin_in got %b want 1", bus.ws_allowin); end
        @(negedge clk);
        bus_idle();
        #1;
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL alu_wen got %b want 1", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d want 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata got %h want 00001234", rf_wdata); end
        checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL alu_allowin got %b want 1", bus.ws_allowin); end
        checks++; if (debug_wb_pc !== 32'h100) begin errors++; $display("FAIL alu_pc got %h want 00000100", debug_wb_pc); end
        exp_retired++;
        $display("alu rd=5 wdata=%h", rf_wdata);
        @(negedge clk);
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL alu_wen_after got %b want 0", rf_wen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev_alu;
        logic [31:0] cur_alu;
        prev_alu = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cur_alu = $urandom;
            if (i < 3) put_instr(32'h200 + 32'(4 * i), 5'(10 + i), 1'b1, 2'b11, 3'b000, cur_alu);
            else       bus_idle();
            #1;
            if (i > 0) begin
                checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL b2b_wen[%0d] got %b want 1", i, rf_wen); end
                checks++; if (rf_waddr !== 5'(9 + i)) begin errors++; $display("FAIL b2b_waddr[%0d] got %0d want %0d", i, rf_waddr, 9 + i); end
                checks++; if (rf_wdata !== prev_alu) begin errors++; $display("FAIL b2b_wdata[%0d] got %h want %h", i, rf_wdata, prev_alu); end
                checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin[%0d] got %b want 1", i, bus.ws_allowin); end
                exp_retired++;
                $display("b2b rd=%0d wdata=%h", rf_waddr, rf_wdata);
            end
            prev_alu = cur_alu;
        end
    endtask

    task automatic test_delayed_lb();
        @(negedge clk);
        put_instr(32'h140, 5'd6, 1'b1, 2'b01, 3'b000, 32'h0000_0103);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_idle();
            #1;
            checks++; if (bus.ws_allowin !== 1'b0) begin errors++; $display("FAIL lb_stall_allowin[%0d] got %b want 0", c, bus.ws_allowin); end
            checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL lb_stall_wen[%0d] got %b want 0", c, rf_wen); end
        end
        @(negedge clk);
        data_rvalid = 1'b1;
        data_rdata  = 32'h80FF_0000;
        #1;
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL lb_wen got %b want 1", rf_wen); end
        checks++; if (rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata got %h want ffffff80", rf_wdata); end
        checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL lb_allowin got %b want 1", bus.ws_allowin); end
        exp_retired++;
        $display("lb rd=6 wdata=%h", rf_wdata);
        @(negedge clk);
        data_rvalid = 1'b0;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [4] = '{3'b101, 3'b001, 3'b100, 3'b010};
        logic [1:0]  offs [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
        logic [31:0] exps [4] = '{32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_0080, 32'hBEEF_8001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_rvalid = 1'b0;
            put_instr(32'h180 + 32'(4 * i), 5'd12, 1'b1, 2'b01, f3s[i], 32'h400 + 32'(offs[i]));
            @(negedge clk);
            bus_idle();
            data_rvalid = 1'b1;
            data_rdata  = 32'hBEEF_8001;
            #1;
            checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL ext_wen[%0d] got %b want 1", i, rf_wen); end
            checks++; if (rf_wdata !== exps[i]) begin errors++; $display("FAIL ext_wdata[%0d] got %h want %h", i, rf_wdata, exps[i]); end
            exp_retired++;
            $display("load f3=%0d off=%0d wdata=%h", f3s[i], offs[i], rf_wdata);
        end
        @(negedge clk);
        data_rvalid = 1'b0;
    endtask

    task automatic test_jal_x0();
        @(negedge clk);
        put_instr(32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 3'b000, $urandom);
        @(negedge clk);
        put_instr(32'h2C0, 5'd0, 1'b1, 2'b00, 3'b000, 32'h55);
        #1;
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL jal_wen got %b want 1", rf_wen); end
        checks++; if (rf_wdata !== 32'h0000_0000) begin errors++; $display("FAIL jal_wdata got %h want 00000000", rf_wdata); end
        exp_retired++;
        $display("jal rd=1 wdata=%h", rf_wdata);
        @(negedge clk);
        bus_idle();
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b want 0", rf_wen); end
        checks++; if (ws_fwd_valid !== 1'b0) begin errors++; $display("FAIL x0_fwd_valid got %b want 0", ws_fwd_valid); end
        checks++; if (ws_fwd_ready !== 1'b1) begin errors++; $display("FAIL x0_fwd_ready got %b want 1", ws_fwd_ready); end
        exp_retired++;
        $display("alu rd=0 retired");
        @(negedge clk);
        #1;
        checks++; if (retire_cnt !== (CNT_EN ? exp_retired : 64'd0)) begin errors++; $display("FAIL x0_cnt got %0d want %0d", retire_cnt, CNT_EN ? exp_retired : 64'd0); end
    endtask

    task automatic test_fwd_stall();
        logic [31:0] r;
        r = $urandom;
        @(negedge clk);
        put_instr(32'h300, 5'd7, 1'b1, 2'b01, 3'b010, 32'h500);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus_idle();
            #1;
            checks++; if (ws_fwd_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid[%0d] got %b want 1", c, ws_fwd_valid); end
            checks++; if (ws_fwd_ready !== 1'b0) begin errors++; $display("FAIL fwd_ready_stall[%0d] got %b want 0", c, ws_fwd_ready); end
            checks++; if (ws_fwd_rd !== 5'd7) begin errors++; $display("FAIL fwd_rd[%0d] got %0d want 7", c, ws_fwd_rd); end
        end
        @(negedge clk);
        data_rvalid = 1'b1;
        data_rdata  = r;
        #1;
        checks++; if (ws_fwd_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready_done got %b want 1", ws_fwd_ready); end
        checks++; if (ws_fwd_data !== r) begin errors++; $display("FAIL fwd_data got %h want %h", ws_fwd_data, r); end
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL fwd_wen got %b want 1", rf_wen); end
        exp_retired++;
        $display("lw rd=7 wdata=%h", rf_wdata);
        @(negedge clk);
        data_rvalid = 1'b0;
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        put_instr(32'h340, 5'd9, 1'b1, 2'b01, 3'b000, 32'h600);
        @(negedge clk);
        bus_idle();
        #1;
        checks++; if (bus.ws_allowin !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b want 0", bus.ws_allowin); end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL midrst_allowin_rst got %b want 1", bus.ws_allowin); end
        checks++; if (ws_fwd_valid !== 1'b0) begin errors++; $display("FAIL midrst_fwd_valid got %b want 0", ws_fwd_valid); end
        exp_retired = 64'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        data_rvalid = 1'b1;
        data_rdata  = $urandom;
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL midrst_wen got %b want 0", rf_wen); end
        checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL midrst_allowin got %b want 1", bus.ws_allowin); end
        checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", retire_cnt); end
        $display("reset mid-load discarded");
        @(negedge clk);
        data_rvalid = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL midrst_wen_after got %b want 0", rf_wen); end
    endtask

    // Model: one held instruction plus the number of cycles until its load data shows up.
    task automatic test_random();
        logic        m_valid = 1'b0;
        logic [31:0] m_pc = 32'd0;
        logic [4:0]  m_rd = 5'd0;
        logic        m_we = 1'b0;
        logic [1:0]  m_sel = 2'b00;
        logic [2:0]  m_f3 = 3'b000;
        logic [31:0] m_alu = 32'd0;
        int          m_wait = 0;
        logic        n_valid;
        logic        held_load;
        logic        ready;
        logic        e_allow;
        logic        e_wen;
        logic        e_fwd_valid;
        logic [31:0] e_val;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            n_valid = ($urandom_range(0, 3) != 0);
            bus.ms_valid      = n_valid;
            bus.ms_pc         = $urandom;
            bus.ms_rd         = 5'($urandom_range(0, 31));
            bus.ms_rf_we      = 1'($urandom_range(0, 1));
            bus.ms_wb_sel     = 2'($urandom_range(0, 3));
            bus.ms_funct3     = 3'($urandom_range(0, 7));
            bus.ms_alu_result = $urandom;
            held_load  = m_valid && (m_sel == 2'b01);
            data_rvalid = held_load ? (m_wait == 0) : ($urandom_range(0, 7) == 0);
            data_rdata  = $urandom;
            #1;
            ready       = !held_load || data_rvalid;
            e_allow     = !m_valid || ready;
            e_wen       = m_valid && ready && m_we && (m_rd != 5'd0);
            e_fwd_valid = m_valid && m_we && (m_rd != 5'd0);
            if (m_sel == 2'b01)      e_val = ref_load(m_f3, m_alu[1:0], data_rdata);
            else if (m_sel == 2'b10) e_val = m_pc + 32'd4;
            else                     e_val = m_alu;

            checks++; if (bus.ws_allowin !== e_allow) begin errors++; $display("FAIL rnd_allowin[%0d] got %b want %b", cyc, bus.ws_allowin, e_allow); end
            checks++; if (rf_wen !== e_wen) begin errors++; $display("FAIL rnd_wen[%0d] got %b want %b", cyc, rf_wen, e_wen); end
            checks++; if (ws_fwd_valid !== e_fwd_valid) begin errors++; $display("FAIL rnd_fwd_valid[%0d] got %b want %b", cyc, ws_fwd_valid, e_fwd_valid); end
            checks++; if (ws_fwd_ready !== (m_valid && ready)) begin errors++; $display("FAIL rnd_fwd_ready[%0d] got %b want %b", cyc, ws_fwd_ready, m_valid && ready); end
            checks++; if (retire_cnt !== (CNT_EN ? exp_retired : 64'd0)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", cyc, retire_cnt, CNT_EN ? exp_retired : 64'd0); end
            if (m_valid) begin
                checks++; if (debug_wb_pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", cyc, debug_wb_pc, m_pc); end
            end
            if (e_wen) begin
                checks++; if (rf_waddr !== m_rd) begin errors++; $display("FAIL rnd_waddr[%0d] got %0d want %0d", cyc, rf_waddr, m_rd); end
                checks++; if (rf_wdata !== e_val) begin errors++; $display("FAIL rnd_wdata[%0d] got %h want %h", cyc, rf_wdata, e_val); end
            end
            if (e_fwd_valid && ready) begin
                checks++; if (ws_fwd_data !== e_val) begin errors++; $display("FAIL rnd_fwd_data[%0d] got %h want %h", cyc, ws_fwd_data, e_val); end
            end

            if (m_valid && ready) begin
                exp_retired++;
                $display("rnd cyc=%0d pc=%h sel=%0d rd=%0d wen=%b wdata=%h", cyc, m_pc, m_sel, m_rd, rf_wen, rf_wdata);
            end
            if (n_valid && e_allow) begin
                m_valid = 1'b1;
                m_pc    = bus.ms_pc;
                m_rd    = bus.ms_rd;
                m_we    = bus.ms_rf_we;
                m_sel   = bus.ms_wb_sel;
                m_f3    = bus.ms_funct3;
                m_alu   = bus.ms_alu_result;
                m_wait  = $urandom_range(0, 3);
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end else if (held_load) begin
                m_wait--;
            end
        end
        @(negedge clk);
        bus_idle();
        data_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_delayed_lb();
        test_load_ext();
        test_jal_x0();
        test_fwd_stall();
        test_reset_midload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
